pwu_retire_arb: RTL and testbench

//  Retire-stage controller for the PWU. Arbitrates NUM_REQ lane responses into the single

---
 rtl/pwu_retire_arb.sv | 165 ++++++++++++++++
 tb/tb_pwu_retire_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwu_retire_arb.sv
// Retire-stage controller for the PWU: round-robin arbitration of lane responses into the
// single retire register stage, backpressure hold, flush, and retire/error statistics.

`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 8
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 4
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 8
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 8
`endif
`ifndef NOU_WL_RM_WIDTH
`define NOU_WL_RM_WIDTH 2
`endif

module pwu_retire_arb #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SID_W    = `NOU_SID_WIDTH,
  parameter int unsigned RSP_W    = `NOU_RSP_TYPE_ID_WIDTH,
  parameter int unsigned PKT_W    = `NOU_PKT_ID_WIDTH,
  parameter int unsigned ERR_W    = `NOU_ERR_CODE_WIDTH,
  parameter int unsigned RM_W     = `NOU_WL_RM_WIDTH,
  parameter bit          ERR_PRIO = 1'b0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_vld,
  output logic [NUM_REQ-1:0]       req_rdy,
  input  logic [NUM_REQ*SID_W-1:0] req_sid,
  input  logic [NUM_REQ*RSP_W-1:0] req_rsp_type,
  input  logic [NUM_REQ*PKT_W-1:0] req_pkt_id,
  input  logic [NUM_REQ-1:0]       req_status,
  input  logic [NUM_REQ*ERR_W-1:0] req_err_code,
  input  logic [NUM_REQ*RM_W-1:0]  req_rm,
  input  logic                     flush,
  input  logic                     rsp_rdy,
  output logic                     retire_keep,
  output logic                     ret_vld,
  output logic [SID_W-1:0]         ret_sid,
  output logic [RSP_W-1:0]         ret_rsp_type,
  output logic [PKT_W-1:0]         ret_pkt_id,
  output logic                     ret_status,
  output logic [ERR_W-1:0]         ret_err_code,
  output logic [RM_W-1:0]          ret_rm,
  output logic [CNT_W-1:0]         ret_cnt,
  output logic [15:0]              err_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } occ_e;

  occ_e               occ_q, occ_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               st_status_q, st_status_d;
  logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  logic [NUM_REQ-1:0] err_mask;
  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [PTR_W-1:0]   found_idx;
  int unsigned        scan_idx;
  logic               load;
  logic               grant_en;
  logic               grant;
  logic               retire_ev;

  // Round-robin search from rr_ptr; error lanes only when error priority applies.
  always_comb begin
    err_mask  = req_vld & req_status;
    cand      = (ERR_PRIO && (|err_mask)) ? err_mask : req_vld;
    found     = 1'b0;
    found_idx = '0;
    scan_idx  = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_idx = (int'(rr_ptr_q) + off) % NUM_REQ;
      if (!found && cand[scan_idx]) begin
        found     = 1'b1;
        found_idx = PTR_W'(scan_idx);
      end
    end
  end

  // Stage control, grant and the mux of the granted lane onto the stage d-inputs.
  always_comb begin
    retire_keep  = (occ_q == StFull) && !rsp_rdy && !flush;
    load         = !retire_keep;
    // rst is included so no grant escapes while reset is held mid-cycle.
    grant_en     = load && !flush && !rst;
    grant        = grant_en && found;
    retire_ev    = (occ_q == StFull) && rsp_rdy && !flush;
    req_rdy      = '0;
    ret_vld      = grant;
    ret_sid      = '0;
    ret_rsp_type = '0;
    ret_pkt_id   = '0;
    ret_status   = 1'b0;
    ret_err_code = '0;
    ret_rm       = '0;
    if (grant) begin
      req_rdy      = NUM_REQ'(1) << found_idx;
      ret_sid      = req_sid[found_idx*SID_W +: SID_W];
      ret_rsp_type = req_rsp_type[found_idx*RSP_W +: RSP_W];
      ret_pkt_id   = req_pkt_id[found_idx*PKT_W +: PKT_W];
      ret_status   = req_status[found_idx];
      ret_err_code = req_err_code[found_idx*ERR_W +: ERR_W];
      ret_rm       = req_rm[found_idx*RM_W +: RM_W];
    end
  end

  // Next-state for occupancy, RR pointer, local status copy and statistics.
  always_comb begin
    occ_d       = occ_q;
    rr_ptr_d    = rr_ptr_q;
    st_status_d = st_status_q;
    ret_cnt_d   = ret_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (load) begin
      occ_d       = ret_vld ? StFull : StEmpty;
      st_status_d = ret_status;
    end
    if (flush) begin
      occ_d    = StEmpty;
      rr_ptr_d = '0;
    end else if (grant) begin
      rr_ptr_d = PTR_W'((int'(found_idx) + 1) % NUM_REQ);
    end
    if (retire_ev) begin
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
      if (st_status_q && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q       <= StEmpty;
      rr_ptr_q    <= '0;
      st_status_q <= 1'b0;
      ret_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      occ_q       <= occ_d;
      rr_ptr_q    <= rr_ptr_d;
      st_status_q <= st_status_d;
      ret_cnt_q   <= ret_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ret_cnt = ret_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pwu_retire_arb.sv
// Directed bench for pwu_retire_arb (NUM_REQ=4, ERR_PRIO=1, CNT_W=8).

module tb_pwu_retire_arb;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SID_W   = 4;
  localparam int unsigned RSP_W   = 3;
  localparam int unsigned PKT_W   = 6;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned RM_W    = 2;
  localparam int unsigned CNT_W   = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ-1:0]       req_rdy;
  logic [NUM_REQ*SID_W-1:0] req_sid;
  logic [NUM_REQ*RSP_W-1:0] req_rsp_type;
  logic [NUM_REQ*PKT_W-1:0] req_pkt_id;
  logic [NUM_REQ-1:0]       req_status;
  logic [NUM_REQ*ERR_W-1:0] req_err_code;
  logic [NUM_REQ*RM_W-1:0]  req_rm;
  logic                     flush;
  logic                     rsp_rdy;
  logic                     retire_keep;
  logic                     ret_vld;
  logic [SID_W-1:0]         ret_sid;
  logic [RSP_W-1:0]         ret_rsp_type;
  logic [PKT_W-1:0]         ret_pkt_id;
  logic                     ret_status;
  logic [ERR_W-1:0]         ret_err_code;
  logic [RM_W-1:0]          ret_rm;
  logic [CNT_W-1:0]         ret_cnt;
  logic [15:0]              err_cnt;

  int checks = 0;
  int errors = 0;

  pwu_retire_arb #(
    .NUM_REQ  (NUM_REQ),
    .SID_W    (SID_W),
    .RSP_W    (RSP_W),
    .PKT_W    (PKT_W),
    .ERR_W    (ERR_W),
    .RM_W     (RM_W),
    .ERR_PRIO (1'b1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_sid      (req_sid),
    .req_rsp_type (req_rsp_type),
    .req_pkt_id   (req_pkt_id),
    .req_status   (req_status),
    .req_err_code (req_err_code),
    .req_rm       (req_rm),
    .flush        (flush),
    .rsp_rdy      (rsp_rdy),
    .retire_keep  (retire_keep),
    .ret_vld      (ret_vld),
    .ret_sid      (ret_sid),
    .ret_rsp_type (ret_rsp_type),
    .ret_pkt_id   (ret_pkt_id),
    .ret_status   (ret_status),
    .ret_err_code (ret_err_code),
    .ret_rm       (ret_rm),
    .ret_cnt      (ret_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fixed per-lane fields: sid=i+1, type=i, pkt=0x10+i, err=0xA+i, rm=3-i.
  task automatic set_fields();
    req_sid      = {4'h4, 4'h3, 4'h2, 4'h1};
    req_rsp_type = {3'd3, 3'd2, 3'd1, 3'd0};
    req_pkt_id   = {6'h13, 6'h12, 6'h11, 6'h10};
    req_err_code = {4'hD, 4'hC, 4'hB, 4'hA};
    req_rm       = {2'd0, 2'd1, 2'd2, 2'd3};
  endtask

  logic [3:0] exp_gnt [5];
  logic [7:0] exp_cnt [5];

  initial begin
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_cnt = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3};

    // Reset held with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_vld      = 4'($urandom);
      req_sid      = 16'($urandom);
      req_rsp_type = 12'($urandom);
      req_pkt_id   = 24'($urandom);
      req_status   = 4'($urandom);
      req_err_code = 16'($urandom);
      req_rm       = 8'($urandom);
      flush        = 1'($urandom);
      rsp_rdy      = 1'($urandom);
      #2;
      chk("rst_keep", retire_keep === 1'b0);
      chk("rst_rdy", req_rdy === 4'b0000);
      chk("rst_vld", ret_vld === 1'b0);
      chk("rst_retcnt", ret_cnt === 8'd0);
      chk("rst_errcnt", err_cnt === 16'd0);
      tick();
    end

    rst        = 1'b0;
    set_fields();
    req_vld    = 4'b0000;
    req_status = 4'b0000;
    flush      = 1'b0;
    rsp_rdy    = 1'b1;
    #2;
    chk("idle_vld", ret_vld === 1'b0);
    chk("idle_sid_zero", ret_sid === 4'h0);
    tick();

    // Round-robin with all lanes requesting and the consumer always ready.
    req_vld = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("rr_gnt", req_rdy === exp_gnt[i]);
      chk("rr_cnt", ret_cnt === exp_cnt[i]);
      tick();
    end
    chk("rr_cnt_end", ret_cnt === 8'd4);

    // Backpressure on a full stage: hold and no grants.
    rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_keep", retire_keep === 1'b1);
      chk("bp_rdy", req_rdy === 4'b0000);
      tick();
    end
    chk("bp_cnt", ret_cnt === 8'd4);
    rsp_rdy = 1'b1;
    #2;
    chk("bp_rel_keep", retire_keep === 1'b0);
    chk("bp_rel_gnt", req_rdy === 4'b0010);
    chk("bp_rel_sid", ret_sid === 4'h2);
    tick();
    chk("bp_rel_cnt", ret_cnt === 8'd5);

    // Flush while full and the consumer stalled.
    rsp_rdy = 1'b0;
    flush   = 1'b1;
    #2;
    chk("fl_keep", retire_keep === 1'b0);
    chk("fl_rdy", req_rdy === 4'b0000);
    chk("fl_vld", ret_vld === 1'b0);
    tick();
    chk("fl_cnt", ret_cnt === 8'd5);
    flush   = 1'b0;
    req_vld = 4'b0000;
    #2;
    chk("fl_occ_empty", retire_keep === 1'b0);
    tick();
    // Pointer was cleared: lane0 wins from a full request set.
    req_vld = 4'b1111;
    #2;
    chk("fl_ptr_zero", req_rdy === 4'b0001);
    tick();

    // Error priority: lane2 (error) beats lane1, then lane1.
    rsp_rdy    = 1'b1;
    req_vld    = 4'b0110;
    req_status = 4'b0100;
    #2;
    chk("ep_gnt_err", req_rdy === 4'b0100);
    chk("ep_status", ret_status === 1'b1);
    chk("ep_type", ret_rsp_type === 3'd2);
    chk("ep_pkt", ret_pkt_id === 6'h12);
    chk("ep_ecode", ret_err_code === 4'hC);
    chk("ep_rm", ret_rm === 2'd1);
    tick();
    chk("ep_cnt1", ret_cnt === 8'd6);
    req_vld    = 4'b0010;
    req_status = 4'b0000;
    #2;
    chk("ep_gnt_clean", req_rdy === 4'b0010);
    tick();
    chk("ep_err1", err_cnt === 16'd1);
    req_vld = 4'b0000;
    #2;
    chk("bubble_vld", ret_vld === 1'b0);
    tick();
    chk("ep_cnt3", ret_cnt === 8'd8);
    chk("bubble_keep", retire_keep === 1'b0);

    // Long stream of error responses: ret_cnt wrap and err_cnt saturation.
    req_vld    = 4'b1111;
    req_status = 4'b1111;
    for (int i = 0; i < 248; i++) tick();
    chk("wrap_ff", ret_cnt === 8'hFF);
    chk("wrap_err", err_cnt === 16'd248);
    tick();
    chk("wrap_00", ret_cnt === 8'h00);
    for (int i = 249; i < 65534; i++) tick();
    chk("sat_fffe", err_cnt === 16'hFFFE);
    chk("sat_cnt", ret_cnt === 8'd5);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_ffff", err_cnt === 16'hFFFF);
    chk("sat_cnt2", ret_cnt === 8'd8);

    // Asynchronous reset in the middle of a cycle with traffic pending.
    rsp_rdy = 1'b0;
    #2;
    chk("pre_rst_keep", retire_keep === 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_keep", retire_keep === 1'b0);
    chk("arst_rdy", req_rdy === 4'b0000);
    chk("arst_vld", ret_vld === 1'b0);
    chk("arst_cnt", ret_cnt === 8'd0);
    chk("arst_err", err_cnt === 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
